// File: rtl/mastermind_game_ctrl_if.sv
// Button/secret inputs and board/status outputs of the Mastermind game sequencer.
// The master side (stimulus or button front end) drives inputs; the slave is the controller.
interface mastermind_game_ctrl_if #(
    parameter int ROWS = 6
);
    logic                 start;
    logic [11:0]          secret_in;
    logic                 btn_left;
    logic                 btn_right;
    logic                 btn_up;
    logic                 btn_down;
    logic                 btn_enter;
    logic [ROWS*12-1:0]   matrix_flat;
    logic [ROWS*6-1:0]    fb_flat;
    logic [2:0]           guess_num;
    logic [1:0]           cursor;
    logic                 q_Init;
    logic                 q_Input;
    logic                 q_Score;
    logic                 q_Win;
    logic                 q_Lose;
    logic [11:0]          secret_out;

    modport master (
        output start, secret_in, btn_left, btn_right, btn_up, btn_down, btn_enter,
        input  matrix_flat, fb_flat, guess_num, cursor,
        input  q_Init, q_Input, q_Score, q_Win, q_Lose, secret_out
    );

    modport slave (
        input  start, secret_in, btn_left, btn_right, btn_up, btn_down, btn_enter,
        output matrix_flat, fb_flat, guess_num, cursor,
        output q_Init, q_Input, q_Score, q_Win, q_Lose, secret_out
    );
endinterface

// File: rtl/mastermind_game_ctrl.sv
// Mastermind game sequencer: owns the guess board, cursor and current row, scores each
// committed row against the latched secret one colour per cycle, and decides win/lose.
module mastermind_game_ctrl #(
    parameter int ROWS    = 6,
    parameter int NCOLORS = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    mastermind_game_ctrl_if.slave  bus
);

    localparam logic [2:0] MAXC    = 3'(NCOLORS);
    localparam logic [2:0] LASTROW = 3'(ROWS - 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_INPUT,
        S_SCORE,
        S_RESULT,
        S_WIN,
        S_LOSE
    } state_t;

    state_t              state, state_next;
    logic [ROWS*12-1:0]  matrix, matrix_next;
    logic [ROWS*6-1:0]   fb, fb_next;
    logic [2:0]          guess_num, guess_next;
    logic [1:0]          cursor, cursor_next;
    logic [11:0]         secret, secret_next;
    logic [2:0]          exact, exact_next;
    logic [2:0]          acc, acc_next;
    logic [2:0]          color_k, color_k_next;
    logic                q_init, q_input, q_score, q_win, q_lose;
    logic [11:0]         secret_q;
    logic [11:0]         cur_row;
    logic [2:0]          cur_peg;
    logic                row_full;

    function automatic logic [2:0] sanitize(input logic [2:0] c);
        return (c == 3'd0 || c > MAXC) ? 3'd1 : c;
    endfunction

    function automatic logic [2:0] count_color(input logic [11:0] row, input logic [2:0] color);
        logic [2:0] n;
        n = 3'd0;
        for (int c = 0; c < 4; c++)
            if (row[c*3 +: 3] == color) n = n + 3'd1;
        return n;
    endfunction

    function automatic logic [2:0] count_exact(input logic [11:0] g, input logic [11:0] s);
        logic [2:0] n;
        n = 3'd0;
        for (int c = 0; c < 4; c++)
            if (g[c*3 +: 3] == s[c*3 +: 3]) n = n + 3'd1;
        return n;
    endfunction

    function automatic logic [2:0] min3(input logic [2:0] a, input logic [2:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [2:0] peg_up(input logic [2:0] p);
        return (p == 3'd0 || p >= MAXC) ? 3'd1 : p + 3'd1;
    endfunction

    function automatic logic [2:0] peg_down(input logic [2:0] p);
        return (p <= 3'd1 || p > MAXC) ? MAXC : p - 3'd1;
    endfunction

    assign cur_row  = matrix[int'(guess_num)*12 +: 12];
    assign cur_peg  = cur_row[int'(cursor)*3 +: 3];
    assign row_full = (cur_row[2:0] != 3'd0) && (cur_row[5:3] != 3'd0) &&
                      (cur_row[8:6] != 3'd0) && (cur_row[11:9] != 3'd0);

    // Next-state and datapath updates; start overrides every state, including mid-score.
    always_comb begin
        state_next   = state;
        matrix_next  = matrix;
        fb_next      = fb;
        guess_next   = guess_num;
        cursor_next  = cursor;
        secret_next  = secret;
        exact_next   = exact;
        acc_next     = acc;
        color_k_next = color_k;

        if (bus.start) begin
            state_next   = S_INPUT;
            matrix_next  = '0;
            fb_next      = '0;
            guess_next   = 3'd0;
            cursor_next  = 2'd0;
            exact_next   = 3'd0;
            acc_next     = 3'd0;
            color_k_next = 3'd0;
            for (int c = 0; c < 4; c++)
                secret_next[c*3 +: 3] = sanitize(bus.secret_in[c*3 +: 3]);
        end else begin
            case (state)
                S_INPUT: begin
                    if (bus.btn_enter) begin
                        // A row with an empty peg cannot be committed; the press is swallowed.
                        if (row_full) begin
                            exact_next   = count_exact(cur_row, secret);
                            acc_next     = 3'd0;
                            color_k_next = 3'd1;
                            state_next   = S_SCORE;
                        end
                    end else if (bus.btn_up) begin
                        matrix_next[int'(guess_num)*12 + int'(cursor)*3 +: 3] = peg_up(cur_peg);
                    end else if (bus.btn_down) begin
                        matrix_next[int'(guess_num)*12 + int'(cursor)*3 +: 3] = peg_down(cur_peg);
                    end else if (bus.btn_left) begin
                        if (cursor != 2'd0) cursor_next = cursor - 2'd1;
                    end else if (bus.btn_right) begin
                        if (cursor != 2'd3) cursor_next = cursor + 2'd1;
                    end
                end
                S_SCORE: begin
                    acc_next     = acc + min3(count_color(cur_row, color_k),
                                              count_color(secret, color_k));
                    color_k_next = color_k + 3'd1;
                    if (color_k == MAXC) state_next = S_RESULT;
                end
                S_RESULT: begin
                    fb_next[int'(guess_num)*6 +: 6] = {acc - exact, exact};
                    if (exact == 3'd4) begin
                        state_next = S_WIN;
                    end else if (guess_num == LASTROW) begin
                        state_next = S_LOSE;
                    end else begin
                        guess_next  = guess_num + 3'd1;
                        cursor_next = 2'd0;
                        state_next  = S_INPUT;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status flags and secret_out are decoded from the next state so they stay registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_INIT;
            matrix    <= '0;
            fb        <= '0;
            guess_num <= 3'd0;
            cursor    <= 2'd0;
            secret    <= 12'd0;
            exact     <= 3'd0;
            acc       <= 3'd0;
            color_k   <= 3'd0;
            q_init    <= 1'b1;
            q_input   <= 1'b0;
            q_score   <= 1'b0;
            q_win     <= 1'b0;
            q_lose    <= 1'b0;
            secret_q  <= 12'd0;
        end else begin
            state     <= state_next;
            matrix    <= matrix_next;
            fb        <= fb_next;
            guess_num <= guess_next;
            cursor    <= cursor_next;
            secret    <= secret_next;
            exact     <= exact_next;
            acc       <= acc_next;
            color_k   <= color_k_next;
            q_init    <= (state_next == S_INIT);
            q_input   <= (state_next == S_INPUT);
            q_score   <= (state_next == S_SCORE) || (state_next == S_RESULT);
            q_win     <= (state_next == S_WIN);
            q_lose    <= (state_next == S_LOSE);
            secret_q  <= (state_next == S_WIN || state_next == S_LOSE) ? secret_next : 12'd0;
        end
    end

    assign bus.matrix_flat = matrix;
    assign bus.fb_flat     = fb;
    assign bus.guess_num   = guess_num;
    assign bus.cursor      = cursor;
    assign bus.q_Init      = q_init;
    assign bus.q_Input     = q_input;
    assign bus.q_Score     = q_score;
    assign bus.q_Win       = q_win;
    assign bus.q_Lose      = q_lose;
    assign bus.secret_out  = secret_q;

endmodule

// File: tb/tb_mastermind_game_ctrl.sv
// Directed self-checking bench for mastermind_game_ctrl with hand-computed expectations.
module tb_mastermind_game_ctrl;

    localparam logic [4:0] B_E = 5'b10000;
    localparam logic [4:0] B_U = 5'b01000;
    localparam logic [4:0] B_D = 5'b00100;
    localparam logic [4:0] B_L = 5'b00010;
    localparam logic [4:0] B_R = 5'b00001;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mastermind_game_ctrl_if #(.ROWS(6)) bus ();

    mastermind_game_ctrl #(.ROWS(6), .NCOLORS(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge so the rising edge samples them cleanly.
    task automatic applyStimulus(input logic st, input logic [4:0] b);
        @(negedge clk);
        bus.start = st;
        {bus.btn_enter, bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = b;
        @(negedge clk);
        bus.start = 1'b0;
        {bus.btn_enter, bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = 5'b0;
    endtask

    task automatic startGame(input logic [11:0] s);
        bus.secret_in = s;
        applyStimulus(1'b1, 5'b0);
    endtask

    task automatic waitScore(input string tag);
        int n;
        n = 0;
        while (bus.q_Score && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, n, 7);
    endtask

    task automatic enterRow(input logic [2:0] c0, input logic [2:0] c1,
                            input logic [2:0] c2, input logic [2:0] c3, input string tag);
        logic [2:0] cols [4];
        cols = '{c0, c1, c2, c3};
        for (int c = 0; c < 4; c++) begin
            repeat (int'(cols[c])) applyStimulus(1'b0, B_U);
            if (c < 3) applyStimulus(1'b0, B_R);
        end
        applyStimulus(1'b0, B_E);
        waitScore(tag);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        bus.start = 1'b0;
        bus.secret_in = 12'h000;
        {bus.btn_enter, bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = 5'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        checkOutput("rst_matrix", bus.matrix_flat, 0);
        checkOutput("rst_fb", bus.fb_flat, 0);
        checkOutput("rst_guess", bus.guess_num, 0);
        checkOutput("rst_cursor", bus.cursor, 0);
        checkOutput("rst_flags", {bus.q_Init, bus.q_Input, bus.q_Score, bus.q_Win, bus.q_Lose}, 5'b10000);
        checkOutput("rst_secret", bus.secret_out, 0);

        applyStimulus(1'b0, B_U);
        applyStimulus(1'b0, B_R);
        applyStimulus(1'b0, B_E);
        checkOutput("init_matrix", bus.matrix_flat, 0);
        checkOutput("init_cursor", bus.cursor, 0);
        checkOutput("init_state", bus.q_Init, 1);

        startGame(12'h8D1);
        checkOutput("start_flags", {bus.q_Init, bus.q_Input, bus.q_Score, bus.q_Win, bus.q_Lose}, 5'b01000);
        checkOutput("start_secret_hidden", bus.secret_out, 0);

        // Row 0 = 4,3,2,1 against 1,2,3,4: no exact, four partials.
        for (int c = 0; c < 4; c++) begin
            repeat (4 - c) applyStimulus(1'b0, B_U);
            if (c < 3) applyStimulus(1'b0, B_R);
        end
        checkOutput("row0_built", bus.matrix_flat[11:0], 12'h29C);
        applyStimulus(1'b0, B_R);
        checkOutput("cursor_sat_right", bus.cursor, 3);
        applyStimulus(1'b0, B_E);
        checkOutput("score_entered", bus.q_Score, 1);
        repeat (6) @(negedge clk);
        checkOutput("score_still", bus.q_Score, 1);
        checkOutput("fb_not_early", bus.fb_flat, 0);
        @(negedge clk);
        checkOutput("row0_fb", bus.fb_flat[5:0], 6'b100_000);
        checkOutput("row0_next_guess", bus.guess_num, 1);
        checkOutput("row0_cursor_reset", bus.cursor, 0);
        checkOutput("row0_back_input", bus.q_Input, 1);

        // Row 1 = 1,1,1,1: one exact, no partial.
        enterRow(3'd1, 3'd1, 3'd1, 3'd1, "row1_latency");
        checkOutput("row1_matrix", bus.matrix_flat[23:12], 12'h249);
        checkOutput("row1_fb", bus.fb_flat[11:6], 6'b000_001);
        checkOutput("row1_guess", bus.guess_num, 2);

        applyStimulus(1'b0, B_E);
        checkOutput("empty_enter_state", bus.q_Input, 1);
        checkOutput("empty_enter_fb", bus.fb_flat, {24'd0, 6'b000_001, 6'b100_000});
        applyStimulus(1'b0, B_L);
        checkOutput("cursor_sat_left", bus.cursor, 0);
        applyStimulus(1'b0, B_D);
        checkOutput("down_empty", bus.matrix_flat[26:24], 3'd6);
        applyStimulus(1'b0, B_U);
        checkOutput("up_wrap", bus.matrix_flat[26:24], 3'd1);
        applyStimulus(1'b0, B_R);
        applyStimulus(1'b0, B_U | B_L);
        checkOutput("up_left_peg", bus.matrix_flat[29:27], 3'd1);
        checkOutput("up_left_cursor", bus.cursor, 1);

        // Complete row 2 as the exact secret 1,2,3,4.
        applyStimulus(1'b0, B_U);
        applyStimulus(1'b0, B_R);
        repeat (3) applyStimulus(1'b0, B_U);
        applyStimulus(1'b0, B_R);
        repeat (4) applyStimulus(1'b0, B_U);
        checkOutput("row2_matrix", bus.matrix_flat[35:24], 12'h8D1);
        checkOutput("rows_above_kept", bus.matrix_flat[23:0], {12'h249, 12'h29C});
        applyStimulus(1'b0, B_E);
        repeat (6) @(negedge clk);
        checkOutput("win_not_early", bus.q_Win, 0);
        @(negedge clk);
        checkOutput("win_flag", bus.q_Win, 1);
        checkOutput("win_fb", bus.fb_flat[17:12], 6'b000_100);
        checkOutput("win_secret", bus.secret_out, 12'h8D1);
        applyStimulus(1'b0, B_U);
        checkOutput("win_hold_matrix", bus.matrix_flat[35:24], 12'h8D1);
        checkOutput("win_hold_state", bus.q_Win, 1);

        // Secret 0,0,0,0 sanitises to 1,1,1,1; six rows of 2s lose.
        startGame(12'h000);
        checkOutput("lose_start_cleared", bus.matrix_flat, 0);
        for (int r = 0; r < 6; r++) begin
            enterRow(3'd2, 3'd2, 3'd2, 3'd2, "lose_row_latency");
            if (r == 4) checkOutput("lose_row5_guess", bus.guess_num, 5);
        end
        checkOutput("lose_flag", bus.q_Lose, 1);
        checkOutput("lose_guess_hold", bus.guess_num, 5);
        checkOutput("lose_fb", bus.fb_flat, 0);
        checkOutput("lose_secret", bus.secret_out, 12'h249);

        // start in the middle of scoring aborts the row; new secret 7,5,0,6 becomes 1,5,1,6.
        startGame(12'h8D1);
        repeat (2) applyStimulus(1'b0, B_U);
        applyStimulus(1'b0, B_R);
        applyStimulus(1'b0, B_U);
        applyStimulus(1'b0, B_R);
        applyStimulus(1'b0, B_U);
        applyStimulus(1'b0, B_R);
        applyStimulus(1'b0, B_U);
        applyStimulus(1'b0, B_E);
        repeat (2) @(negedge clk);
        checkOutput("mid_score", bus.q_Score, 1);
        bus.secret_in = 12'hF46;
        applyStimulus(1'b1, 5'b0);
        checkOutput("abort_flags", {bus.q_Init, bus.q_Input, bus.q_Score, bus.q_Win, bus.q_Lose}, 5'b01000);
        checkOutput("abort_matrix", bus.matrix_flat, 0);
        checkOutput("abort_cursor", bus.cursor, 0);
        repeat (8) @(negedge clk);
        checkOutput("abort_no_fb", bus.fb_flat, 0);
        checkOutput("abort_guess", bus.guess_num, 0);
        enterRow(3'd6, 3'd1, 3'd5, 3'd1, "abort_win_latency");
        checkOutput("abort_win", bus.q_Win, 1);
        checkOutput("abort_win_fb", bus.fb_flat[5:0], 6'b000_100);
        checkOutput("abort_secret", bus.secret_out, 12'h34E);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
